// File: rtl/byte_cmd_encoder_if.sv
// byte_cmd_encoder_if: command ingress, byte egress and status signals of byte_cmd_encoder
`timescale 1ns/1ps
interface byte_cmd_encoder_if;
    logic [23:0] WriteAddr;
    logic [31:0] WriteData;
    logic        WriteDataValid;
    logic        Ready;
    logic [7:0]  ED;
    logic        EValid;
    logic        Rdyn;
    logic        Busy;
    modport master (output WriteAddr, WriteData, WriteDataValid, Rdyn, input Ready, ED, EValid, Busy);
    modport slave  (input WriteAddr, WriteData, WriteDataValid, Rdyn, output Ready, ED, EValid, Busy);
endinterface

// File: rtl/byte_cmd_encoder.sv
// byte_cmd_encoder: buffers addr/data write commands and serializes each into a 7-byte MSB-first frame
`timescale 1ns/1ps
module byte_cmd_encoder #(
    parameter int CMD_FIFO_DEPTH      = 4,
    parameter int CMD_FIFO_DEPTH_LOG2 = 2,
    parameter int GAP_CYCLES          = 0
) (
    input logic Clk,
    input logic Rst,
    byte_cmd_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t state, state_nxt;
    logic [55:0] mem [CMD_FIFO_DEPTH];
    logic [CMD_FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CMD_FIFO_DEPTH_LOG2:0] count;
    logic [55:0] shreg;
    logic [2:0] idx;
    logic [7:0] gap_cnt;
    logic has_cmd, push, pop, xfer, last, gap_load;
    assign has_cmd = count != '0;
    assign bus.Ready = count != (CMD_FIFO_DEPTH_LOG2+1)'(CMD_FIFO_DEPTH);
    assign push = bus.WriteDataValid && bus.Ready;
    assign bus.EValid = state == SEND;
    assign bus.ED = shreg[55:48];
    assign bus.Busy = has_cmd || state != IDLE;
    assign xfer = bus.EValid && !bus.Rdyn;
    assign last = xfer && idx == 3'd6;
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (state == IDLE && has_cmd) state_nxt = SEND;
        else if (last) state_nxt = GAP_CYCLES > 0 ? GAP : (has_cmd ? SEND : IDLE);
        else if (state == GAP && gap_cnt == 8'd1) state_nxt = IDLE;
    end
    // back-to-back frames pop on the last transfer so the next first byte follows without a bubble
    always_comb begin
        pop = has_cmd && (state == IDLE || (last && GAP_CYCLES == 0));
        gap_load = last && GAP_CYCLES > 0;
    end
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= {bus.WriteAddr, bus.WriteData};
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (CMD_FIFO_DEPTH_LOG2+1)'(push) - (CMD_FIFO_DEPTH_LOG2+1)'(pop);
        end
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            shreg <= '0;
            idx <= '0;
            gap_cnt <= '0;
        end else begin
            if (pop) begin
                shreg <= mem[rd_ptr];
                idx <= '0;
            end else if (xfer && !last) begin
                shreg <= {shreg[47:0], 8'h00};
                idx <= idx + 3'd1;
            end
            if (gap_load) gap_cnt <= 8'(GAP_CYCLES);
            else if (state == GAP) gap_cnt <= gap_cnt - 8'd1;
        end
    end
endmodule

// File: tb/tb_byte_cmd_encoder.sv
// tb_byte_cmd_encoder: table, directed and randomized loopback checks for byte_cmd_encoder
`timescale 1ns/1ps
module tb_byte_cmd_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [55:0] cmd_q[$];
    typedef struct { logic [23:0] a; logic [31:0] d; logic [55:0] f; } vec_t;
    vec_t tbl[3];
    int cyc[14];
    int n;
    int sent, got, nb;
    logic [55:0] acc;
    logic [23:0] ra;
    logic [31:0] rd;
    always #5 clk = ~clk;
    byte_cmd_encoder_if bus0();
    byte_cmd_encoder_if bus3();
    assign bus3.WriteAddr = bus0.WriteAddr;
    assign bus3.WriteData = bus0.WriteData;
    assign bus3.WriteDataValid = bus0.WriteDataValid;
    assign bus3.Rdyn = bus0.Rdyn;
    byte_cmd_encoder #(.CMD_FIFO_DEPTH(4), .CMD_FIFO_DEPTH_LOG2(2), .GAP_CYCLES(0)) dut0 (.Clk(clk), .Rst(rst), .bus(bus0.slave));
    byte_cmd_encoder #(.CMD_FIFO_DEPTH(4), .CMD_FIFO_DEPTH_LOG2(2), .GAP_CYCLES(3)) dut3 (.Clk(clk), .Rst(rst), .bus(bus3.slave));
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic add_frame(input logic [23:0] a, input logic [31:0] d);
        for (int j = 6; j >= 0; j--) exp_q.push_back(8'({a, d} >> (8 * j)));
    endtask
    task automatic push(input logic [23:0] a, input logic [31:0] d);
        bus0.WriteAddr = a;
        bus0.WriteData = d;
        bus0.WriteDataValid = 1'b1;
        tick;
        bus0.WriteDataValid = 1'b0;
    endtask
    task automatic do_reset;
        rst = 1'b1;
        bus0.WriteDataValid = 1'b0;
        bus0.Rdyn = 1'b0;
        exp_q.delete();
        tick;
        tick;
        rst = 1'b0;
    endtask
    // watches transfers on dut0 against exp_q; mode 1 toggles Rdyn every cycle
    task automatic drain(input int mode, input int max);
        logic pev = 1'b0;
        logic prdy = 1'b0;
        logic [7:0] ped = 8'h00;
        for (int c = 0; c < max; c++) begin
            bus0.Rdyn = mode == 1 ? ~bus0.Rdyn : 1'b0;
            if (bus0.EValid && pev && prdy) chk("hold_ed", bus0.ED, ped);
            if (bus0.EValid && !bus0.Rdyn) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte got %0h want none", bus0.ED);
                end else chk("byte_ed", bus0.ED, exp_q.pop_front());
            end
            pev = bus0.EValid;
            prdy = bus0.Rdyn;
            ped = bus0.ED;
            tick;
        end
        bus0.Rdyn = 1'b0;
        chk("bytes_left", exp_q.size(), 0);
    endtask
    initial begin
        bus0.WriteAddr = '0;
        bus0.WriteData = '0;
        bus0.WriteDataValid = 1'b0;
        bus0.Rdyn = 1'b0;
        tbl[0] = '{24'h000104, 32'hDEADBEEF, 56'h000104DEADBEEF};
        tbl[1] = '{24'hFFFFFF, 32'h00000000, 56'hFFFFFF00000000};
        tbl[2] = '{24'hA5C301, 32'h12345678, 56'hA5C30112345678};
        do_reset;
        chk("rst_ed", bus0.ED, 8'h00);
        chk("rst_evalid", bus0.EValid, 1'b0);
        chk("rst_busy", bus0.Busy, 1'b0);
        chk("rst_ready", bus0.Ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            push(tbl[i].a, tbl[i].d);
            chk("lat_ev0", bus0.EValid, 1'b0);
            tick;
            for (int j = 0; j < 7; j++) begin
                chk("tbl_ev", bus0.EValid, 1'b1);
                chk("tbl_ed", bus0.ED, tbl[i].f[55 - 8 * j -: 8]);
                tick;
            end
            chk("tbl_busy", bus0.Busy, 1'b0);
            chk("tbl_end", bus0.EValid, 1'b0);
        end
        // the first command leaves the FIFO immediately, so four more fill it
        do_reset;
        bus0.Rdyn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("fill_ready", bus0.Ready, i < 5);
            if (i < 5) add_frame(24'(i * 24'h010203 + 1), 32'hC0DE0000 + 32'(i));
            push(24'(i * 24'h010203 + 1), 32'hC0DE0000 + 32'(i));
        end
        bus0.Rdyn = 1'b0;
        for (int k = 0; k < 35; k++) begin
            chk("b2b_ev", bus0.EValid, 1'b1);
            chk("b2b_ed", bus0.ED, exp_q.pop_front());
            tick;
        end
        chk("b2b_end", bus0.EValid, 1'b0);
        chk("b2b_ready", bus0.Ready, 1'b1);
        do_reset;
        add_frame(24'h5A5A5A, 32'h0F0F0F0F);
        push(24'h5A5A5A, 32'h0F0F0F0F);
        drain(1, 40);
        do_reset;
        add_frame(24'h111111, 32'h22222222);
        add_frame(24'h333333, 32'h44444444);
        push(24'h111111, 32'h22222222);
        push(24'h333333, 32'h44444444);
        n = 0;
        for (int i = 0; i < 14; i++) cyc[i] = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus3.EValid) begin
                if (n < 14) begin
                    cyc[n] = c;
                    chk("gap_ed", bus3.ED, exp_q.pop_front());
                end
                n++;
            end
            tick;
        end
        chk("gap_n", n, 14);
        chk("gap_frame1", cyc[6] - cyc[0], 6);
        chk("gap_spacing", cyc[7] - cyc[6], 5);
        chk("gap_frame2", cyc[13] - cyc[7], 6);
        do_reset;
        push(24'h123456, 32'h789ABCDE);
        tick;
        tick;
        tick;
        tick;
        chk("mid_byte3", bus0.ED, 8'h78);
        bus0.Rdyn = 1'b1;
        push(24'h654321, 32'h0BADF00D);
        chk("mid_hold", bus0.ED, 8'h78);
        rst = 1'b1;
        tick;
        chk("mid_rst_ev", bus0.EValid, 1'b0);
        chk("mid_rst_ready", bus0.Ready, 1'b1);
        chk("mid_rst_busy", bus0.Busy, 1'b0);
        rst = 1'b0;
        bus0.Rdyn = 1'b0;
        exp_q.delete();
        add_frame(24'hABCDEF, 32'h01020304);
        push(24'hABCDEF, 32'h01020304);
        drain(0, 20);
        do_reset;
        cmd_q.delete();
        fork
            begin
                sent = 0;
                for (int c = 0; c < 6000 && sent < 50; c++) begin
                    if (bus0.Ready && $urandom_range(0, 2) != 0) begin
                        ra = 24'($urandom);
                        rd = $urandom;
                        bus0.WriteAddr = ra;
                        bus0.WriteData = rd;
                        bus0.WriteDataValid = 1'b1;
                        cmd_q.push_back({ra, rd});
                        sent++;
                    end else bus0.WriteDataValid = 1'b0;
                    tick;
                end
                bus0.WriteDataValid = 1'b0;
            end
            begin
                got = 0;
                nb = 0;
                acc = '0;
                for (int c = 0; c < 8000 && got < 50; c++) begin
                    bus0.Rdyn = $urandom_range(0, 3) == 0;
                    if (bus0.EValid && !bus0.Rdyn) begin
                        acc = {acc[47:0], bus0.ED};
                        nb++;
                        if (nb == 7) begin
                            nb = 0;
                            got++;
                            if (cmd_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL loop_extra got %0h want none", acc);
                            end else chk("loop_cmd", acc, cmd_q.pop_front());
                        end
                    end
                    tick;
                end
                bus0.Rdyn = 1'b0;
                chk("loop_count", got, 50);
            end
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
